// File: rtl/ps2_scan_funcmod.sv
// rtl/ps2_scan_funcmod.sv - PS/2 keyboard receiver: filter, deframe, prefix merge, show-ahead FIFO
module ps2_scan_funcmod #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              PS2_CLK,
    input  logic              PS2_DAT,
    input  logic              iRead,
    input  logic              iClr,
    output logic [9:0]        oData,
    output logic              oEmpty,
    output logic              oFull,
    output logic [ADDR_W:0]   oCount,
    output logic              oErr,
    output logic [1:0]        oErrCode,
    output logic              oOverflow,
    output logic [3:0]        oState
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DATA   = 4'd1,
        PARITY = 4'd2,
        STOP   = 4'd3
    } stateType;

    logic [1:0]      clkSync;
    logic [1:0]      datSync;
    logic            clkS;
    logic            datS;
    logic            filtClk;
    logic [7:0]      filtCnt;
    logic            fallEvt;

    stateType        state;
    stateType        stateNext;
    logic [2:0]      bitCnt;
    logic [7:0]      shiftReg;
    logic            parBit;
    logic [TO_W-1:0] toCnt;
    logic            timeoutHit;
    logic            errNow;
    logic [1:0]      errCodeNow;
    logic            byteGood;

    logic            goodValid;
    logic [7:0]      goodByte;
    logic            extFlag;
    logic            brkFlag;
    logic            isExt;
    logic            isBrk;
    logic            pushEn;
    logic [9:0]      pushData;

    logic [9:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   count;
    logic              isFull;
    logic              doPop;
    logic              doPush;

    assign clkS = clkSync[1];
    assign datS = datSync[1];

    // Two-stage synchronisers; lines idle high so they reset high.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            clkSync <= 2'b11;
            datSync <= 2'b11;
        end else begin
            clkSync <= {clkSync[0], PS2_CLK};
            datSync <= {datSync[0], PS2_DAT};
        end
    end

    // Clock filter: adopt a new level only after it has held FILT_LEN cycles; strobe on 1->0.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            filtClk <= 1'b1;
            filtCnt <= 8'd0;
            fallEvt <= 1'b0;
        end else begin
            fallEvt <= 1'b0;
            if (clkS != filtClk) begin
                if (filtCnt == 8'(FILT_LEN - 1)) begin
                    filtClk <= clkS;
                    filtCnt <= 8'd0;
                    fallEvt <= filtClk;
                end else begin
                    filtCnt <= filtCnt + 8'd1;
                end
            end else begin
                filtCnt <= 8'd0;
            end
        end
    end

    // The watchdog counter holds 1 in the cycle after a fall, so it hits the
    // limit exactly TIMEOUT_CYC cycles after the last fall event.
    assign timeoutHit = !fallEvt && (toCnt == TO_W'(TIMEOUT_CYC - 1));

    // Deframer next-state and per-cycle error/good-byte decisions.
    always_comb begin
        stateNext  = state;
        errNow     = 1'b0;
        errCodeNow = 2'b00;
        byteGood   = 1'b0;
        case (state)
            IDLE: begin
                if (fallEvt && !datS) stateNext = DATA;
            end
            DATA: begin
                if (fallEvt) begin
                    if (bitCnt == 3'd7) stateNext = PARITY;
                end else if (timeoutHit) begin
                    errNow     = 1'b1;
                    errCodeNow = 2'b11;
                    stateNext  = IDLE;
                end
            end
            PARITY: begin
                if (fallEvt) begin
                    stateNext = STOP;
                end else if (timeoutHit) begin
                    errNow     = 1'b1;
                    errCodeNow = 2'b11;
                    stateNext  = IDLE;
                end
            end
            STOP: begin
                if (fallEvt) begin
                    stateNext = IDLE;
                    if (!datS) begin
                        errNow     = 1'b1;
                        errCodeNow = 2'b10;
                    end else if (^{shiftReg, parBit} == 1'b0) begin
                        errNow     = 1'b1;
                        errCodeNow = 2'b01;
                    end else begin
                        byteGood = 1'b1;
                    end
                end else if (timeoutHit) begin
                    errNow     = 1'b1;
                    errCodeNow = 2'b11;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Deframer state register, data shifter and inter-edge watchdog.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            bitCnt   <= 3'd0;
            shiftReg <= 8'd0;
            parBit   <= 1'b0;
            toCnt    <= TO_W'(1);
        end else begin
            state <= stateNext;
            if (state == IDLE || fallEvt) toCnt <= TO_W'(1);
            else                          toCnt <= toCnt + TO_W'(1);
            if (fallEvt) begin
                case (state)
                    IDLE:    bitCnt <= 3'd0;
                    DATA: begin
                        shiftReg <= {datS, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                    end
                    PARITY:  parBit <= datS;
                    default: ;
                endcase
            end
        end
    end

    // Error reporting and good-byte register; a fresh error beats a clear.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            oErr      <= 1'b0;
            oErrCode  <= 2'b00;
            goodValid <= 1'b0;
            goodByte  <= 8'd0;
        end else begin
            oErr      <= errNow;
            goodValid <= byteGood;
            if (byteGood) goodByte <= shiftReg;
            if (errNow)    oErrCode <= errCodeNow;
            else if (iClr) oErrCode <= 2'b00;
        end
    end

    assign isExt    = (goodByte == 8'hE0);
    assign isBrk    = (goodByte == 8'hF0);
    assign pushEn   = goodValid && !isExt && !isBrk;
    assign pushData = {brkFlag, extFlag, goodByte};

    // Prefix flags: E0/F0 arm them, any other byte consumes them, errors drop them.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            extFlag <= 1'b0;
            brkFlag <= 1'b0;
        end else if (errNow) begin
            extFlag <= 1'b0;
            brkFlag <= 1'b0;
        end else if (goodValid) begin
            if (isExt) begin
                extFlag <= 1'b1;
            end else if (isBrk) begin
                brkFlag <= 1'b1;
            end else begin
                extFlag <= 1'b0;
                brkFlag <= 1'b0;
            end
        end
    end

    assign isFull = (count == (ADDR_W + 1)'(FIFO_DEPTH));
    assign doPop  = iRead && (count != '0);
    assign doPush = pushEn && (!isFull || doPop);

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge CLOCK) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + ADDR_W'(1);
            if (doPop)  rdPtr <= rdPtr + ADDR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (pushEn && !doPush) oOverflow <= 1'b1;
            else if (iClr)         oOverflow <= 1'b0;
        end
    end

    assign oData  = (count == '0) ? 10'd0 : mem[rdPtr];
    assign oEmpty = (count == '0);
    assign oFull  = isFull;
    assign oCount = count;
    assign oState = state;

endmodule

// File: tb/tb_ps2_scan_funcmod.sv
// tb/tb_ps2_scan_funcmod.sv - directed scoreboard bench for ps2_scan_funcmod
module tb_ps2_scan_funcmod;

    localparam int FILT  = 8;
    localparam int TO    = 1000;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int HALF  = 20;

    logic          CLOCK = 1'b0;
    logic          RST_n = 1'b0;
    logic          PS2_CLK = 1'b1;
    logic          PS2_DAT = 1'b1;
    logic          iRead = 1'b0;
    logic          iClr = 1'b0;
    logic [9:0]    oData;
    logic          oEmpty;
    logic          oFull;
    logic [AW:0]   oCount;
    logic          oErr;
    logic [1:0]    oErrCode;
    logic          oOverflow;
    logic [3:0]    oState;

    ps2_scan_funcmod #(
        .FILT_LEN(FILT), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .CLOCK(CLOCK), .RST_n(RST_n), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .iRead(iRead), .iClr(iClr), .oData(oData), .oEmpty(oEmpty), .oFull(oFull),
        .oCount(oCount), .oErr(oErr), .oErrCode(oErrCode), .oOverflow(oOverflow),
        .oState(oState)
    );

    always #5 CLOCK = ~CLOCK;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] expQ[$];
    logic       expOvf;

    int         cyc = 0;
    int         sinceFall = 0;
    int         errGap = -1;
    int         errLen = 0;
    int         lastErrLen = 0;
    int         errPulses = 0;
    int         nonIdleCnt = 0;
    int         stopRetCyc = -1;
    int         emptyFallCyc = -1;
    logic [3:0] prevState = 4'd0;
    logic       prevEmpty = 1'b1;

    // Passive monitor sampling on the falling edge.
    always @(negedge CLOCK) begin
        cyc++;
        if (dut.fallEvt) sinceFall = 0;
        else             sinceFall++;
        if (oErr) begin
            if (errLen == 0) begin
                errGap = sinceFall;
                errPulses++;
            end
            errLen++;
        end else begin
            if (errLen != 0) lastErrLen = errLen;
            errLen = 0;
        end
        if (prevState == 4'd3 && oState == 4'd0) stopRetCyc = cyc;
        if (prevEmpty && !oEmpty) emptyFallCyc = cyc;
        if (oState != 4'd0) nonIdleCnt++;
        prevState = oState;
        prevEmpty = oEmpty;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit, summary required", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic stopBit, input int nBits);
        logic [10:0] fr;
        fr = {stopBit, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            @(negedge CLOCK);
            PS2_DAT = fr[i];
            waitCyc(HALF);
            PS2_CLK = 1'b0;
            waitCyc(HALF);
            PS2_CLK = 1'b1;
        end
        @(negedge CLOCK);
        PS2_DAT = 1'b1;
        waitCyc(HALF);
    endtask

    task automatic expectPush(input logic [9:0] v);
        if (expQ.size() < DEPTH) expQ.push_back(v);
        else                     expOvf = 1'b1;
    endtask

    task automatic readCheck(input string tag);
        logic [9:0] e;
        e = expQ.pop_front();
        check({tag, "_data"}, 32'(oData), 32'(e));
        iRead = 1'b1;
        @(negedge CLOCK);
        iRead = 1'b0;
        check({tag, "_count"}, 32'(oCount), 32'(expQ.size()));
    endtask

    task automatic checkResetVals(input string p);
        check({p, "_oData"},     32'(oData),     32'h0);
        check({p, "_oEmpty"},    32'(oEmpty),    32'h1);
        check({p, "_oFull"},     32'(oFull),     32'h0);
        check({p, "_oCount"},    32'(oCount),    32'h0);
        check({p, "_oErr"},      32'(oErr),      32'h0);
        check({p, "_oErrCode"},  32'(oErrCode),  32'h0);
        check({p, "_oOverflow"}, 32'(oOverflow), 32'h0);
        check({p, "_oState"},    32'(oState),    32'h0);
    endtask

    initial begin
        int p0;
        int n0;
        logic [9:0] e;
        expOvf = 1'b0;

        waitCyc(3);
        checkResetVals("rst0");
        RST_n = 1'b1;
        waitCyc(30);

        // Single frame, latency and pop.
        sendFrame(8'h1C, 1'b0, 1'b1, 11);
        expectPush(10'h01C);
        check("t1_latency", 32'(emptyFallCyc - stopRetCyc), 32'd1);
        check("t1_count", 32'(oCount), 32'(expQ.size()));
        check("t1_empty", 32'(oEmpty), 32'h0);
        readCheck("t1_pop");
        check("t1_empty_after", 32'(oEmpty), 32'h1);

        // Prefix merge then a plain byte.
        sendFrame(8'hE0, 1'b0, 1'b1, 11);
        sendFrame(8'hF0, 1'b0, 1'b1, 11);
        sendFrame(8'h75, 1'b0, 1'b1, 11);
        expectPush(10'h375);
        check("t2_count", 32'(oCount), 32'(expQ.size()));
        sendFrame(8'h1C, 1'b0, 1'b1, 11);
        expectPush(10'h01C);
        readCheck("t2_ext_brk");
        readCheck("t2_plain");

        // Parity and framing errors, then clear.
        p0 = errPulses;
        sendFrame(8'h1C, 1'b1, 1'b1, 11);
        check("t3_par_pulses", 32'(errPulses - p0), 32'd1);
        check("t3_par_len", 32'(lastErrLen), 32'd1);
        check("t3_par_code", 32'(oErrCode), 32'h1);
        check("t3_par_count", 32'(oCount), 32'(expQ.size()));
        sendFrame(8'h1C, 1'b0, 1'b0, 11);
        check("t3_stop_pulses", 32'(errPulses - p0), 32'd2);
        check("t3_stop_code", 32'(oErrCode), 32'h2);
        iClr = 1'b1;
        @(negedge CLOCK);
        iClr = 1'b0;
        check("t3_clr_code", 32'(oErrCode), 32'h0);

        // Timeout after four data bits.
        p0 = errPulses;
        sendFrame(8'h5A, 1'b0, 1'b1, 5);
        for (int i = 0; i < 1500 && errPulses == p0; i++) @(negedge CLOCK);
        check("t4_pulse", 32'(errPulses - p0), 32'd1);
        check("t4_gap", 32'(errGap), 32'(TO));
        check("t4_code", 32'(oErrCode), 32'h3);
        check("t4_state", 32'(oState), 32'h0);
        waitCyc(5);
        sendFrame(8'h2A, 1'b0, 1'b1, 11);
        expectPush(10'h02A);
        readCheck("t4_after");

        // Fill past capacity.
        sendFrame(8'h16, 1'b0, 1'b1, 11); expectPush(10'h016);
        sendFrame(8'h1E, 1'b0, 1'b1, 11); expectPush(10'h01E);
        sendFrame(8'h26, 1'b0, 1'b1, 11); expectPush(10'h026);
        sendFrame(8'h25, 1'b0, 1'b1, 11); expectPush(10'h025);
        sendFrame(8'h2E, 1'b0, 1'b1, 11); expectPush(10'h02E);
        check("t5_full", 32'(oFull), 32'(expQ.size() == DEPTH));
        check("t5_count", 32'(oCount), 32'(expQ.size()));
        check("t5_ovf", 32'(oOverflow), 32'(expOvf));
        iClr = 1'b1;
        @(negedge CLOCK);
        iClr = 1'b0;
        expOvf = 1'b0;
        check("t5_ovf_clr", 32'(oOverflow), 32'(expOvf));
        readCheck("t5_r0");
        readCheck("t5_r1");
        readCheck("t5_r2");
        readCheck("t5_r3");

        // Refill, then push and pop together while full.
        sendFrame(8'h16, 1'b0, 1'b1, 11); expectPush(10'h016);
        sendFrame(8'h1E, 1'b0, 1'b1, 11); expectPush(10'h01E);
        sendFrame(8'h26, 1'b0, 1'b1, 11); expectPush(10'h026);
        sendFrame(8'h25, 1'b0, 1'b1, 11); expectPush(10'h025);
        check("t5_refull", 32'(oFull), 32'(expQ.size() == DEPTH));
        fork
            sendFrame(8'h36, 1'b0, 1'b1, 11);
            begin
                for (int i = 0; i < 1000 && oState != 4'd3; i++) @(negedge CLOCK);
                for (int i = 0; i < 1000 && oState != 4'd0; i++) @(negedge CLOCK);
                e = expQ.pop_front();
                check("t5_simul_head", 32'(oData), 32'(e));
                iRead = 1'b1;
                @(negedge CLOCK);
                iRead = 1'b0;
            end
        join
        expectPush(10'h036);
        check("t5_simul_count", 32'(oCount), 32'(expQ.size()));
        check("t5_simul_ovf", 32'(oOverflow), 32'(expOvf));
        readCheck("t5_s0");
        readCheck("t5_s1");
        readCheck("t5_s2");
        readCheck("t5_s3");

        // Short clock glitch in IDLE with data low.
        n0 = nonIdleCnt;
        p0 = errPulses;
        @(negedge CLOCK);
        PS2_DAT = 1'b0;
        waitCyc(5);
        PS2_CLK = 1'b0;
        waitCyc(3);
        PS2_CLK = 1'b1;
        waitCyc(30);
        PS2_DAT = 1'b1;
        check("t6_glitch_state", 32'(nonIdleCnt - n0), 32'd0);
        check("t6_glitch_err", 32'(errPulses - p0), 32'd0);
        waitCyc(5);

        // Reset mid-frame with a queued entry and an armed break prefix.
        sendFrame(8'h1C, 1'b0, 1'b1, 11);
        expectPush(10'h01C);
        check("t7_pre_count", 32'(oCount), 32'(expQ.size()));
        sendFrame(8'hF0, 1'b0, 1'b1, 11);
        sendFrame(8'h55, 1'b0, 1'b1, 4);
        check("t7_mid_state", 32'(oState), 32'h1);
        RST_n = 1'b0;
        waitCyc(2);
        checkResetVals("rst1");
        expQ.delete();
        RST_n = 1'b1;
        waitCyc(30);
        sendFrame(8'h75, 1'b0, 1'b1, 11);
        expectPush(10'h075);
        readCheck("t7_after");
        check("t7_empty", 32'(oEmpty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
